// File: rtl/car_park_pkg.sv
// Shared types and constants for the car park gate controller.
// Sensor patterns are written as {a, b}: a is the outer beam, b the inner beam.
package car_park_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_COUNT = 4'd15;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_A    = 2'b10;
  localparam logic [1:0] P_B    = 2'b01;
  localparam logic [1:0] P_AB   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    EN_A,
    EN_AB,
    EN_B,
    EX_B,
    EX_BA,
    EX_A,
    WAIT_CLR
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down occupancy counter with registered full/empty flags.
// Flags are computed from the next count so they track count with no extra lag.
module sat_counter
  import car_park_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (inc && !dec && (count != MAX_COUNT)) begin
      count_next = count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_next;
      full  <= (count_next == MAX_COUNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/car_park_fsm.sv
// Gate sequencer: decodes the two-beam sensor order into entries and exits
// and drives the occupancy counter; state is exported for observation.
module car_park_fsm
  import car_park_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             car_in,
  output logic             car_out,
  output logic             seq_err,
  output state_t           state
);

  state_t     state_next;
  logic [1:0] sensors;
  logic       inc_req;
  logic       dec_req;
  logic       err_req;

  assign sensors = {a, b};

  // Each path state: hold on its own pattern, advance on the next one,
  // back off on the previous one, abort on 00, anything else is illegal.
  always_comb begin
    state_next = state;
    inc_req    = 1'b0;
    dec_req    = 1'b0;
    err_req    = 1'b0;
    case (state)
      IDLE: begin
        case (sensors)
          P_NONE:  state_next = IDLE;
          P_A:     state_next = EN_A;
          P_B:     state_next = EX_B;
          default: begin state_next = WAIT_CLR; err_req = 1'b1; end
        endcase
      end
      EN_A: begin
        case (sensors)
          P_A:     state_next = EN_A;
          P_AB:    state_next = EN_AB;
          P_NONE:  state_next = IDLE;
          default: begin state_next = WAIT_CLR; err_req = 1'b1; end
        endcase
      end
      EN_AB: begin
        case (sensors)
          P_AB:    state_next = EN_AB;
          P_B:     state_next = EN_B;
          P_A:     state_next = EN_A;
          default: state_next = IDLE;
        endcase
      end
      EN_B: begin
        case (sensors)
          P_B:     state_next = EN_B;
          P_NONE:  begin state_next = IDLE; inc_req = 1'b1; end
          P_AB:    state_next = EN_AB;
          default: begin state_next = WAIT_CLR; err_req = 1'b1; end
        endcase
      end
      EX_B: begin
        case (sensors)
          P_B:     state_next = EX_B;
          P_AB:    state_next = EX_BA;
          P_NONE:  state_next = IDLE;
          default: begin state_next = WAIT_CLR; err_req = 1'b1; end
        endcase
      end
      EX_BA: begin
        case (sensors)
          P_AB:    state_next = EX_BA;
          P_A:     state_next = EX_A;
          P_B:     state_next = EX_B;
          default: state_next = IDLE;
        endcase
      end
      EX_A: begin
        case (sensors)
          P_A:     state_next = EX_A;
          P_NONE:  begin state_next = IDLE; dec_req = 1'b1; end
          P_AB:    state_next = EX_BA;
          default: begin state_next = WAIT_CLR; err_req = 1'b1; end
        endcase
      end
      WAIT_CLR: begin
        if (sensors == P_NONE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pulses only report counts that actually moved, so saturated events are silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      car_in  <= 1'b0;
      car_out <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      state   <= state_next;
      car_in  <= inc_req && !full;
      car_out <= dec_req && !empty;
      seq_err <= err_req;
    end
  end

  sat_counter u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_req),
    .dec   (dec_req),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_car_park_fsm.sv
// Randomised and directed bench for car_park_fsm against a path-list model
// of the gate rules; every cycle's outputs are scored in order.
module tb_car_park_fsm;
  import car_park_pkg::*;

  logic             clk;
  logic             reset;
  logic             a;
  logic             b;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             car_in;
  logic             car_out;
  logic             seq_err;
  state_t           state;

  car_park_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .car_in  (car_in),
    .car_out (car_out),
    .seq_err (seq_err),
    .state   (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard: {count, full, empty, car_in, car_out, seq_err}
  logic [8:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int act_in     = 0;
  int act_out    = 0;
  int act_err    = 0;

  // reference model: the list of distinct patterns seen since the gate was clear
  int         m_count = 0;
  logic [1:0] m_path[$];
  bit         m_wait  = 1'b0;

  function automatic logic [1:0] path_pat(input logic [1:0] dir, input int idx);
    logic [1:0] r;
    r = 2'b11;
    if (idx == 0) r = dir;
    else if (idx == 2) r = (dir == 2'b10) ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic model_step(input bit r, input logic [1:0] p, output logic [8:0] e);
    bit ci, co, er;
    int n;
    ci = 0; co = 0; er = 0;
    if (r) begin
      m_count = 0;
      m_path.delete();
      m_wait = 0;
    end else if (m_wait) begin
      if (p == 2'b00) m_wait = 0;
    end else if (m_path.size() == 0) begin
      if (p == 2'b10 || p == 2'b01) m_path.push_back(p);
      else if (p == 2'b11) begin er = 1; m_wait = 1; end
    end else if (p != m_path[$]) begin
      n = m_path.size();
      if (n < 3 && p == path_pat(m_path[0], n)) begin
        m_path.push_back(p);
      end else if (p == ((n >= 2) ? path_pat(m_path[0], n - 2) : 2'b00)) begin
        if (n == 1) m_path.delete();
        else void'(m_path.pop_back());
      end else if (p == 2'b00) begin
        if (n == 3) begin
          if (m_path[0] == 2'b10) begin
            if (m_count < 15) begin m_count++; ci = 1; end
          end else begin
            if (m_count > 0) begin m_count--; co = 1; end
          end
        end
        m_path.delete();
      end else begin
        er = 1;
        m_wait = 1;
        m_path.delete();
      end
    end
    e = {m_count[3:0], (m_count == 15), (m_count == 0), ci, co, er};
  endtask

  // driver
  task automatic drive(input bit r, input logic [1:0] p);
    logic [8:0] e;
    @(negedge clk);
    reset = r;
    {a, b} = p;
    model_step(r, p, e);
    exp_q.push_back(e);
  endtask

  // plays n patterns packed MSB-first, each held for hold cycles
  task automatic play(input logic [23:0] pats, input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      for (int h = 0; h < hold; h++) drive(1'b0, pats[2*(n-1-i) +: 2]);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expected outputs still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // monitor
  initial begin
    logic [8:0] act;
    logic [8:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {count, full, empty, car_in, car_out, seq_err};
        compared++;
        if (act !== exp_v) begin
          mismatched++;
          $display("FAIL outputs @%0t: got %b required %b (count,full,empty,in,out,err)",
                   $time, act, exp_v);
        end
        if (car_in === 1'b1) act_in++;
        if (car_out === 1'b1) act_out++;
        if (seq_err === 1'b1) act_err++;
      end
    end
  end

  // stimulus
  initial begin
    int base_in, base_out, base_err, kind, hold;
    reset = 1'b1;
    a = 1'b0;
    b = 1'b0;
    drive(1'b1, 2'b11);
    drive(1'b1, 2'b10);
    drive(1'b1, 2'b00);
    drain();
    check_int("reset_count", int'(count), 0);
    check_int("reset_empty", int'(empty), 1);

    for (int k = 0; k < 15; k++) play({2'b00, 2'b10, 2'b11, 2'b01, 2'b00}, 5, 2);
    drain();
    check_int("fill_count", int'(count), 15);
    check_int("fill_full", int'(full), 1);
    check_int("fill_car_in_pulses", act_in, 15);

    base_in = act_in;
    play({2'b00, 2'b10, 2'b11, 2'b01, 2'b00}, 5, 2);
    drain();
    check_int("sat_entry_count", int'(count), 15);
    check_int("sat_entry_no_pulse", act_in - base_in, 0);

    base_out = act_out;
    for (int k = 0; k < 16; k++) play({2'b00, 2'b01, 2'b11, 2'b10, 2'b00}, 5, 2);
    drain();
    check_int("drain_count", int'(count), 0);
    check_int("drain_empty", int'(empty), 1);
    check_int("drain_car_out_pulses", act_out - base_out, 15);

    play({2'b00, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00}, 6, 1);
    play({2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00}, 6, 1);
    drain();
    check_int("stretched_entries", int'(count), 2);
    play({2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00}, 6, 1);
    drain();
    check_int("stretched_exit", int'(count), 1);

    base_in = act_in;
    play({2'b00, 2'b10, 2'b11, 2'b10, 2'b00}, 5, 1);
    drain();
    check_int("abort_count", int'(count), 1);
    check_int("abort_no_pulse", act_in - base_in, 0);

    base_err = act_err;
    play({2'b00, 2'b10, 2'b01, 2'b00}, 4, 1);
    drain();
    check_int("illegal_seq_err", act_err - base_err, 1);
    check_int("illegal_count", int'(count), 1);
    check_int("illegal_then_idle", int'(state == IDLE), 1);

    for (int k = 0; k < 6; k++) play({2'b00, 2'b10, 2'b11, 2'b01, 2'b00}, 5, 1);
    drain();
    check_int("pre_reset_count", int'(count), 7);
    play({2'b00, 2'b10, 2'b11}, 3, 1);
    drive(1'b1, 2'b11);
    play({2'b01, 2'b00}, 2, 1);
    drain();
    check_int("mid_reset_count", int'(count), 0);
    check_int("mid_reset_idle", int'(state == IDLE), 1);

    // randomised traffic, walks and occasional resets
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 5);
      hold = $urandom_range(1, 3);
      case (kind)
        0, 1: play({2'b00, 2'b10, 2'b11, 2'b01, 2'b00}, 5, hold);
        2:    play({2'b00, 2'b01, 2'b11, 2'b10, 2'b00}, 5, hold);
        3, 4: for (int s = 0; s < 10; s++) drive(1'b0, 2'($urandom_range(0, 3)));
        default: begin
          if ($urandom_range(0, 3) == 0) drive(1'b1, 2'($urandom_range(0, 3)));
          else drive(1'b0, 2'b00);
        end
      endcase
    end
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
